// File: rtl/vc_scheduler_if.sv
// Bus between the VC scheduler, the VC source FIFOs and the destination FIFOs.
// The scheduler takes the master side. The FIFOs and demux take the slave side.
interface vc_scheduler_if #(
    parameter int WORD_SIZE = 6
);
    logic                 vc0_empty;
    logic                 vc1_empty;
    logic [WORD_SIZE-1:0] vc0_data;
    logic [WORD_SIZE-1:0] vc1_data;
    logic                 pause_d0;
    logic                 pause_d1;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic [WORD_SIZE-1:0] data_out;
    logic                 push_d0;
    logic                 push_d1;

    modport master (
        input  vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
        output pop_vc0, pop_vc1, data_out, push_d0, push_d1
    );

    modport slave (
        output vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
        input  pop_vc0, pop_vc1, data_out, push_d0, push_d1
    );
endinterface

// File: rtl/vc_scheduler.sv
// Weighted round-robin mover from the VC0/VC1 FIFOs to the D0/D1 FIFOs, routed by word bit 4.
// Latency: grant in cycle N, pop in N+1, push in N+3. Sustains 1 word/cycle.
// Backpressure: either pause stops new grants at once. In-flight words always complete.
module vc_scheduler #(
    parameter int WORD_SIZE  = 6,
    parameter int VC0_WEIGHT = 3,
    parameter int VC1_WEIGHT = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    vc_scheduler_if.master   bus,
    output logic [1:0]       state,
    output logic             busy,
    output logic [CNT_W-1:0] vc0_count,
    output logic [CNT_W-1:0] vc1_count
);
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SERVE_VC0 = 2'b01,
        SERVE_VC1 = 2'b10
    } state_t;

    localparam logic [3:0] W0 = (VC0_WEIGHT == 0) ? 4'd1 : 4'(VC0_WEIGHT);
    localparam logic [3:0] W1 = (VC1_WEIGHT == 0) ? 4'd1 : 4'(VC1_WEIGHT);

    state_t               st_q, st_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ok, e0, e1, cur, e_cur, e_oth;
    logic [3:0]           w_cur;
    logic                 gnt_cur, gnt_oth, gnt0, gnt1;
    logic                 rd_vld, rd_src;
    logic [WORD_SIZE-1:0] word;

    // The destination is unknown until the word is read, so either pause blocks both VCs.
    assign ok    = enable & ~bus.pause_d0 & ~bus.pause_d1;
    assign e0    = ok & ~bus.vc0_empty;
    assign e1    = ok & ~bus.vc1_empty;
    assign cur   = (st_q == SERVE_VC1);
    assign e_cur = cur ? e1 : e0;
    assign e_oth = cur ? e0 : e1;
    assign w_cur = cur ? W1 : W0;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        gnt_cur = 1'b0;
        gnt_oth = 1'b0;
        case (st_q)
            IDLE: begin
                if (enable) begin
                    st_d  = SERVE_VC0;
                    cnt_d = 4'd0;
                end
            end
            default: begin
                if (!enable) begin
                    st_d = IDLE;
                end else if (e_cur && (cnt_q < w_cur)) begin
                    gnt_cur = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                end else if (e_oth) begin
                    gnt_oth = 1'b1;
                    st_d    = cur ? SERVE_VC0 : SERVE_VC1;
                    cnt_d   = 4'd1;
                end else if (e_cur) begin
                    // Turn used up, but the other VC has nothing, so start a fresh turn.
                    gnt_cur = 1'b1;
                    cnt_d   = 4'd1;
                end
            end
        endcase
    end

    assign gnt0 = (gnt_cur & ~cur) | (gnt_oth & cur);
    assign gnt1 = (gnt_cur & cur) | (gnt_oth & ~cur);
    assign word = rd_src ? bus.vc1_data : bus.vc0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= IDLE;
            cnt_q        <= 4'd0;
            bus.pop_vc0  <= 1'b0;
            bus.pop_vc1  <= 1'b0;
            rd_vld       <= 1'b0;
            rd_src       <= 1'b0;
            bus.data_out <= '0;
            bus.push_d0  <= 1'b0;
            bus.push_d1  <= 1'b0;
            vc0_count    <= '0;
            vc1_count    <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            bus.pop_vc0 <= gnt0;
            bus.pop_vc1 <= gnt1;
            rd_vld      <= bus.pop_vc0 | bus.pop_vc1;
            rd_src      <= bus.pop_vc1;
            // The read data is valid one cycle after the pop. Capture it and push in the same step.
            if (rd_vld) begin
                bus.data_out <= word;
                bus.push_d0  <= ~word[4];
                bus.push_d1  <= word[4];
                if (rd_src) vc1_count <= vc1_count + CNT_W'(1);
                else        vc0_count <= vc0_count + CNT_W'(1);
            end else begin
                bus.push_d0 <= 1'b0;
                bus.push_d1 <= 1'b0;
            end
        end
    end

    assign state = st_q;
    assign busy  = rd_vld | bus.push_d0 | bus.push_d1;
endmodule

// File: doc/vc_scheduler.md
Name: vc_scheduler

Overview:
- Weighted round-robin scheduler that moves words from the VC0/VC1 FIFOs to the D0/D1 destination FIFOs.
- Replaces the ad-hoc VC pop/valid logic with a single controller that does four things:
  - issues pops to the VC FIFOs;
  - captures the returned word;
  - routes it by destination bit [4];
  - backs off on destination pause.
- Sits between FIFO_VC0/FIFO_VC1 and the mux/demux_DEST path; enabled by the state machine's active_out.

Parameters:
- WORD_SIZE, 6, width of a data word.
- VC0_WEIGHT, 3, consecutive grants VC0 may take per turn (1..15; 0 behaves as 1).
- VC1_WEIGHT, 1, consecutive grants VC1 may take per turn (1..15; 0 behaves as 1).
- CNT_W, 8, width of per-VC forwarded-word counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scheduling allowed (driven by active_out).
- vc0_empty  in  1  FIFO_VC0 empty flag (reflects all pops up to previous cycle).
- vc1_empty  in  1  FIFO_VC1 empty flag.
- vc0_data  in  WORD_SIZE  FIFO_VC0 read data, valid the cycle after pop_vc0.
- vc1_data  in  WORD_SIZE  FIFO_VC1 read data, valid the cycle after pop_vc1.
- pause_d0  in  1  FIFO_D0 almost_full.
- pause_d1  in  1  FIFO_D1 almost_full.
- pop_vc0  out  1  read strobe to FIFO_VC0.
- pop_vc1  out  1  read strobe to FIFO_VC1.
- data_out  out  WORD_SIZE  word to destination FIFOs.
- push_d0  out  1  write strobe to FIFO_D0.
- push_d1  out  1  write strobe to FIFO_D1.
- state  out  2  00 IDLE, 01 SERVE_VC0, 10 SERVE_VC1.
- busy  out  1  a word is in flight (stage 1 or stage 2 valid).
- vc0_count  out  CNT_W  words forwarded from VC0, wraps modulo 2^CNT_W.
- vc1_count  out  CNT_W  words forwarded from VC1, wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) forces all outputs, pipeline valids and counters to 0.
  - state=IDLE, cur=VC0, turn counter cnt=0.
  - Words in flight at reset are discarded: no push is issued for them.
- Eligibility (combinational): ok = enable & ~pause_d0 & ~pause_d1; e0 = ok & ~vc0_empty; e1 = ok & ~vc1_empty.
  - Either pause stalls both VCs, because the destination is unknown before the read.
  - D FIFO almost_full thresholds must leave at least 2 entries of slack for in-flight words.
- Grant rule, evaluated each cycle, at most one grant per cycle:
  - e_cur & cnt<W_cur: grant cur, cnt<=cnt+1.
  - else e_other: grant other, cur<=other, cnt<=1.
  - else e_cur (turn exhausted, other not eligible): grant cur, cnt<=1.
  - else: no grant; cur and cnt hold.
- pop_vcX is registered: asserted in cycle N+1 for a grant decided in cycle N. pop_vc0 and pop_vc1 are never high together.
- FSM:
  - IDLE -> SERVE_VC0 when enable=1 (cur=VC0, cnt=0).
  - SERVE_VCx reflects cur and follows the grant rule.
  - Any SERVE state -> IDLE when enable=0. New grants stop immediately; in-flight words still complete their pushes.
- Pipeline:
  - Stage 1: the cycle after a pop, capture vcX_data into a holding register along with its source.
  - Stage 2: next cycle, data_out <= captured word.
  - push_d0 = ~word[4]; push_d1 = word[4]; exactly one push per popped word.
  - Latency: pop high in cycle P -> push high in cycle P+2.
  - Sustained throughput: 1 word/cycle.
- Counters:
  - vcX_count increments in the cycle its push is issued.
  - Wraps from 2^CNT_W-1 to 0.
- data_out holds its last value when no push is issued.
- Simultaneous events:
  - A pause asserted in the same cycle as a candidate grant blocks that grant.
  - Pushes already in the pipeline complete regardless of pause.
  - enable falling with pause high: no new pops; in-flight words complete.

Test Plan:
1. Reset mid-stream: pop_vc0 issued, reset asserted at the next edge -> no push_d0/push_d1 ever appears for that word; counters=0; state=00.
2. Weighting: both VCs hold 8 words, pauses low, enable=1 -> pop order 0,0,0,1,0,0,0,1. vc0_count=6 and vc1_count=2 after 8 pushes.
3. Single VC: VC1 empty, VC0 holds 5 words -> 5 consecutive pop_vc0 cycles with no bubble. Pushes arrive 2 cycles after each pop; state stays 01.
4. Routing: VC1 words 6'b110000 and 6'b100000 -> push_d1 with data_out=110000, then push_d0 with data_out=100000.
5. Pause: pause_d1=1 during a stream -> pops stop the next cycle; the 2 in-flight words are still pushed. Pops resume 1 cycle after pause_d1 clears.
6. Wrap: CNT_W=2, 5 VC0 words forwarded -> vc0_count sequence 1,2,3,0,1.
